// File: rtl/ind_ram_lookup_arbiter.sv
// Shares one indirection-RAM port between NUM_REQ round-robin readers and a config writer.
// Read responses return one-hot tagged, RAM_LAT+2 cycles after the handshake.
module ind_ram_lookup_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ADDR_W        = 11,
   parameter int DATA_W        = 8,
   parameter int RAM_LAT       = 2,
   parameter int MAX_CFG_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic                      cfg_wr_valid,
   input  logic [ADDR_W-1:0]         cfg_wr_addr,
   input  logic [DATA_W-1:0]         cfg_wr_data,
   output logic                      cfg_wr_ready,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic                      ram_en,
   output logic                      ram_we,
   output logic [DATA_W-1:0]         ram_din,
   input  logic [DATA_W-1:0]         ram_dout,
   output logic                      busy
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_CFG_BURST + 1);

   logic [ADDR_W-1:0]  req_addr_arr [NUM_REQ];
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   cfg_cnt_q, cfg_cnt_d;
   logic               any_req, burst_full, grant_wr, grant_rd;
   logic [PTR_W-1:0]   grant_idx;
   int                 idx;

   logic [ADDR_W-1:0]  ram_addr_q;
   logic               ram_en_q, ram_we_q;
   logic [DATA_W-1:0]  ram_din_q;
   logic [NUM_REQ-1:0] tag_q [RAM_LAT+1];
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [DATA_W-1:0]  rsp_data_q;
   logic               busy_c;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
         assign req_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Handshakes are suppressed during reset so no request is consumed and then lost.
   assign any_req    = |req_valid;
   assign burst_full = (cfg_cnt_q == CNT_W'(MAX_CFG_BURST));
   assign grant_wr   = !rst && cfg_wr_valid && !(any_req && burst_full);
   assign grant_rd   = !rst && !grant_wr && any_req;

   always_comb begin
      grant_idx = '0;
      idx       = 0;
      // Descending scan: the last hit is the nearest index at or after rr_ptr.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            grant_idx = PTR_W'(idx);
         end
      end
   end

   assign req_ready    = grant_rd ? (NUM_REQ'(1) << grant_idx) : '0;
   assign cfg_wr_ready = grant_wr;

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      cfg_cnt_d = cfg_cnt_q;
      if (grant_rd) begin
         if (int'(grant_idx) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
         end
      end
      if (grant_rd || !any_req) begin
         cfg_cnt_d = '0;
      end else if (grant_wr && !burst_full) begin
         cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         cfg_cnt_q  <= '0;
         ram_addr_q <= '0;
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_din_q  <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         cfg_cnt_q <= cfg_cnt_d;
         ram_en_q  <= grant_rd;
         ram_we_q  <= grant_wr;
         if (grant_wr) begin
            ram_addr_q <= cfg_wr_addr;
            ram_din_q  <= cfg_wr_data;
         end else if (grant_rd) begin
            ram_addr_q <= req_addr_arr[grant_idx];
         end
      end
   end

   // Stage 0 lines up with ram_en; the last stage lines up with valid ram_dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= RAM_LAT; k++) begin
            tag_q[k] <= '0;
         end
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         tag_q[0] <= req_ready;
         for (int k = 1; k <= RAM_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
         rsp_valid_q <= tag_q[RAM_LAT];
         if (|tag_q[RAM_LAT]) begin
            rsp_data_q <= ram_dout;
         end
      end
   end

   always_comb begin
      busy_c = |rsp_valid_q;
      for (int k = 0; k <= RAM_LAT; k++) begin
         busy_c = busy_c | (|tag_q[k]);
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_din   = ram_din_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_c;

endmodule
